// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates core and debug ports onto a
// single-port synchronous RAM, sequences sub-word stores as read-modify-write
// and returns extended load data.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | arbitrate and accept a request
// S_RD     | RAM read issued for a load / debug read
// S_RESP   | RAM data returned to the owning requester
// S_WR     | full-word RAM write
// S_RMW_RD | RAM read of the word targeted by SB/SH
// S_RMW_WR | merged word written back
// S_ERR    | one-cycle error pulse to the core
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_funct3_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_ready_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ready_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RESP, S_WR, S_RMW_RD, S_RMW_WR, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              last_dbg_q, last_dbg_d;   // 1: debug was granted last, so core wins a tie
  logic              own_dbg_q, own_dbg_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              grant_core, grant_dbg, core_bad;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_ext, merged;

  // Round-robin grant; nothing is accepted while reset is held.
  always_comb begin
    grant_core = arst_n && (state_q == S_IDLE) && core_req_i && (!dbg_req_i || last_dbg_q);
    grant_dbg  = arst_n && (state_q == S_IDLE) && dbg_req_i && (!core_req_i || !last_dbg_q);
  end

  // Illegal funct3 or misaligned core access.
  always_comb begin
    core_bad = 1'b0;
    case (core_funct3_i)
      3'd0:    core_bad = 1'b0;
      3'd1:    core_bad = core_addr_i[0];
      3'd2:    core_bad = |core_addr_i[1:0];
      3'd4:    core_bad = core_we_i;
      3'd5:    core_bad = core_we_i | core_addr_i[0];
      default: core_bad = 1'b1;
    endcase
  end

  // Lane selection and extension of returned data, plus sub-word merge for RMW.
  always_comb begin
    sel_byte = ram_rdata_i[7:0];
    case (addr_q[1:0])
      2'd0: sel_byte = ram_rdata_i[7:0];
      2'd1: sel_byte = ram_rdata_i[15:8];
      2'd2: sel_byte = ram_rdata_i[23:16];
      2'd3: sel_byte = ram_rdata_i[31:24];
      default: sel_byte = ram_rdata_i[7:0];
    endcase
    sel_half = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    case (f3_q)
      3'd0:    load_ext = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      3'd1:    load_ext = {{(DATA_W-16){sel_half[15]}}, sel_half};
      3'd4:    load_ext = {{(DATA_W-8){1'b0}}, sel_byte};
      3'd5:    load_ext = {{(DATA_W-16){1'b0}}, sel_half};
      default: load_ext = ram_rdata_i;
    endcase
    merged = ram_rdata_i;
    if (f3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_rdata_i;
      endcase
    end
  end

  // Next state, request capture and all outputs.
  always_comb begin
    state_d      = state_q;
    last_dbg_d   = last_dbg_q;
    own_dbg_d    = own_dbg_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_ready_o  = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = core_rdata_q;
    core_err_o    = 1'b0;
    dbg_ready_o   = 1'b0;
    dbg_rvalid_o  = 1'b0;
    dbg_rdata_o   = dbg_rdata_q;
    ram_en_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_core) begin
          core_ready_o = 1'b1;
          last_dbg_d   = 1'b0;
          own_dbg_d    = 1'b0;
          we_d         = core_we_i;
          f3_d         = core_funct3_i;
          addr_d       = core_addr_i;
          wdata_d      = core_wdata_i;
          if (core_bad)                   state_d = S_ERR;
          else if (!core_we_i)            state_d = S_RD;
          else if (core_funct3_i == 3'd2) state_d = S_WR;
          else                            state_d = S_RMW_RD;
        end else if (grant_dbg) begin
          dbg_ready_o = 1'b1;
          last_dbg_d  = 1'b1;
          own_dbg_d   = 1'b1;
          we_d        = dbg_we_i;
          f3_d        = 3'd2;
          addr_d      = dbg_addr_i;
          wdata_d     = dbg_wdata_i;
          state_d     = dbg_we_i ? S_WR : S_RD;
        end
      end
      S_RD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (own_dbg_q) begin
          dbg_rvalid_o = 1'b1;
          dbg_rdata_o  = ram_rdata_i;
          dbg_rdata_d  = ram_rdata_i;
        end else begin
          core_rvalid_o = 1'b1;
          core_rdata_o  = load_ext;
          core_rdata_d  = load_ext;
        end
        state_d = S_IDLE;
      end
      S_WR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        ram_wdata_o = wdata_q;
        state_d     = S_IDLE;
      end
      S_RMW_RD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        ram_wdata_o = merged;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        core_err_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      last_dbg_q   <= 1'b1;
      own_dbg_q    <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      own_dbg_q    <= own_dbg_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural RAM, table of core accesses,
// scoreboard queues for read data / RAM writes / error pulses, and
// hand sequences for arbitration, reset abort and back-to-back timing.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_funct3_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_ready_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i;
  logic        dbg_ready_o, dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        busy_o;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_funct3_i(core_funct3_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_ready_o(core_ready_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ready_o(dbg_ready_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  // Single-port synchronous RAM: read data appears the cycle after the read.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o[7:2]] <= ram_wdata_o;
      else          ram_rdata_i <= mem[ram_addr_o[7:2]];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp;
    int          kind;   // 0 load, 1 SW, 2 SB/SH, 3 error
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] crd_q[$];
  logic [31:0] drd_q[$];
  logic        err_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mon_e;
  wr_t         mon_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard side: pop expectations whenever the DUT produces a result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_rvalid_o) begin
        if (crd_q.size() == 0) chk("unexp_core_rvalid", 32'(core_rvalid_o), 0);
        else begin
          mon_e = crd_q.pop_front();
          chk("core_rdata", core_rdata_o, mon_e);
        end
      end
      if (dbg_rvalid_o) begin
        if (drd_q.size() == 0) chk("unexp_dbg_rvalid", 32'(dbg_rvalid_o), 0);
        else begin
          mon_e = drd_q.pop_front();
          chk("dbg_rdata", dbg_rdata_o, mon_e);
        end
      end
      if (core_err_o) begin
        if (err_q.size() == 0) chk("unexp_core_err", 32'(core_err_o), 0);
        else chk("core_err", 32'(core_err_o), 32'(err_q.pop_front()));
      end
      if (ram_en_o && ram_we_o) begin
        if (wr_q.size() == 0) chk("unexp_ram_write", 32'(ram_we_o), 0);
        else begin
          mon_w = wr_q.pop_front();
          chk("ram_waddr", ram_addr_o, mon_w.addr);
          chk("ram_wdata", ram_wdata_o, mon_w.data);
        end
      end
      if (!ram_en_o) chk("ram_idle", ram_addr_o | ram_wdata_o | 32'(ram_we_o), 0);
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic core_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int kind,
                          input string nm);
    int t;
    wr_t w;
    core_req_i = 1'b1; core_we_i = we; core_funct3_i = f3;
    core_addr_i = addr; core_wdata_i = wdata;
    w.addr = addr & 32'hFFFF_FFFC;
    w.data = exp;
    case (kind)
      0: crd_q.push_back(exp);
      1, 2: wr_q.push_back(w);
      default: err_q.push_back(1'b1);
    endcase
    #1;
    t = 0;
    while (!core_ready_o && t < 20) begin @(negedge clk); t++; end
    chk({nm, "_ready"}, 32'(core_ready_o), 1);
    @(negedge clk);
    core_req_i = 1'b0;
    if (kind == 3) begin
      chk({nm, "_err_t1"}, 32'(core_err_o), 1);
      chk({nm, "_no_ram"}, 32'(ram_en_o), 0);
    end else begin
      chk({nm, "_en_t1"}, 32'(ram_en_o), 1);
      chk({nm, "_we_t1"}, 32'(ram_we_o), (kind == 1) ? 32'd1 : 32'd0);
      chk({nm, "_addr_t1"}, ram_addr_o, addr & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    case (kind)
      0: chk({nm, "_rvalid_t2"}, 32'(core_rvalid_o), 1);
      2: chk({nm, "_we_t2"}, 32'(ram_en_o & ram_we_o), 1);
      default: chk({nm, "_idle_t2"}, 32'(busy_o), 0);
    endcase
    if (kind == 0 || kind == 2) begin
      @(negedge clk);
      chk({nm, "_idle_t3"}, 32'(busy_o), 0);
    end
  endtask

  task automatic dbg_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input string nm);
    int t;
    wr_t w;
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata;
    w.addr = addr & 32'hFFFF_FFFC;
    w.data = wdata;
    if (we) wr_q.push_back(w);
    else    drd_q.push_back(exp);
    #1;
    t = 0;
    while (!dbg_ready_o && t < 20) begin @(negedge clk); t++; end
    chk({nm, "_ready"}, 32'(dbg_ready_o), 1);
    @(negedge clk);
    dbg_req_i = 1'b0;
    chk({nm, "_en_t1"}, 32'(ram_en_o), 1);
    chk({nm, "_we_t1"}, 32'(ram_we_o), 32'(we));
    @(negedge clk);
    if (we) chk({nm, "_idle_t2"}, 32'(busy_o), 0);
    else begin
      chk({nm, "_rvalid_t2"}, 32'(dbg_rvalid_o), 1);
      @(negedge clk);
      chk({nm, "_idle_t3"}, 32'(busy_o), 0);
    end
  endtask

  vec_t vecs[19];

  initial begin
    int   acc, cyc, last_cyc, t;
    logic [3:0] order;

    vecs[0]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'h88776655, 32'hFFFFFF88, 0};
    vecs[1]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h88776655, 32'h00000088, 0};
    vecs[2]  = '{1'b0, 3'd5, 32'h12, 32'h0,        32'h88776655, 32'h00008877, 0};
    vecs[3]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'h88776655, 32'hFFFF8877, 0};
    vecs[4]  = '{1'b0, 3'd0, 32'h10, 32'h0,        32'h88776655, 32'h00000055, 0};
    vecs[5]  = '{1'b0, 3'd1, 32'h10, 32'h0,        32'h88776655, 32'h00006655, 0};
    vecs[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h88776655, 32'h88776655, 0};
    vecs[7]  = '{1'b0, 3'd4, 32'h11, 32'h0,        32'h88776655, 32'h00000066, 0};
    vecs[8]  = '{1'b1, 3'd0, 32'h11, 32'h000000AB, 32'h88776655, 32'h8877AB55, 2};
    vecs[9]  = '{1'b1, 3'd1, 32'h12, 32'h00001234, 32'h88776655, 32'h12346655, 2};
    vecs[10] = '{1'b1, 3'd0, 32'h13, 32'hFFFFFF01, 32'h88776655, 32'h01776655, 2};
    vecs[11] = '{1'b1, 3'd1, 32'h10, 32'hFFFFBEEF, 32'h88776655, 32'h8877BEEF, 2};
    vecs[12] = '{1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 1};
    vecs[13] = '{1'b1, 3'd1, 32'h21, 32'h0,        32'h0,        32'h0,        3};
    vecs[14] = '{1'b0, 3'd3, 32'h20, 32'h0,        32'h0,        32'h0,        3};
    vecs[15] = '{1'b0, 3'd2, 32'h22, 32'h0,        32'h0,        32'h0,        3};
    vecs[16] = '{1'b0, 3'd1, 32'h11, 32'h0,        32'h0,        32'h0,        3};
    vecs[17] = '{1'b1, 3'd4, 32'h20, 32'h0,        32'h0,        32'h0,        3};
    vecs[18] = '{1'b0, 3'd6, 32'h20, 32'h0,        32'h0,        32'h0,        3};

    arst_n = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_funct3_i = 3'd0;
    core_addr_i = '0; core_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ram_en", 32'(ram_en_o), 0);
    chk("rst_core_rdata", core_rdata_o, 0);
    chk("rst_dbg_rdata", dbg_rdata_o, 0);
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].kind != 3)
        dbg_txn(1'b1, vecs[i].addr, vecs[i].init, 32'h0, $sformatf("pre%0d", i));
      core_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
               vecs[i].kind, $sformatf("vec%0d", i));
    end

    // Debug write ignores addr[1:0]; core reads it back.
    dbg_txn(1'b1, 32'h43, 32'hDEADBEEF, 32'h0, "dbg_wr");
    core_txn(1'b0, 3'd2, 32'h40, 32'h0, 32'hDEADBEEF, 0, "lw_after_dbg");
    dbg_txn(1'b0, 32'h41, 32'h0, 32'hDEADBEEF, "dbg_rd");

    // Error followed immediately by a held request: next accept two cycles on.
    core_req_i = 1'b1; core_we_i = 1'b1; core_funct3_i = 3'd1; core_addr_i = 32'h21;
    err_q.push_back(1'b1);
    #1;
    t = 0;
    while (!core_ready_o && t < 20) begin @(negedge clk); t++; end
    chk("b2b_err_ready", 32'(core_ready_o), 1);
    @(negedge clk);
    core_we_i = 1'b0; core_funct3_i = 3'd2; core_addr_i = 32'h40;
    #1;
    chk("b2b_err_pulse", 32'(core_err_o), 1);
    chk("b2b_busy_ready", 32'(core_ready_o), 0);
    chk("b2b_no_ram", 32'(ram_en_o), 0);
    @(negedge clk);
    chk("b2b_next_accept", 32'(core_ready_o), 1);
    crd_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    core_req_i = 1'b0;
    repeat (3) @(negedge clk);

    // Both ports held with reads: alternate grants, one every three cycles.
    dbg_txn(1'b1, 32'h30, 32'h11111111, 32'h0, "arb_pre0");
    dbg_txn(1'b1, 32'h34, 32'h22222222, 32'h0, "arb_pre1");
    core_req_i = 1'b1; core_we_i = 1'b0; core_funct3_i = 3'd2; core_addr_i = 32'h30;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h34;
    #1;
    acc = 0; cyc = 0; last_cyc = 0; order = 4'b0000;
    while (acc < 4 && cyc < 40) begin
      if (core_ready_o || dbg_ready_o) begin
        chk("arb_single_grant", 32'(core_ready_o & dbg_ready_o), 0);
        if (core_ready_o) crd_q.push_back(32'h11111111);
        else              drd_q.push_back(32'h22222222);
        order[acc] = dbg_ready_o;
        if (acc > 0) chk("arb_spacing", 32'(cyc - last_cyc), 3);
        last_cyc = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    core_req_i = 1'b0; dbg_req_i = 1'b0;
    chk("arb_count", 32'(acc), 4);
    chk("arb_order", 32'(order), 32'b1010);
    repeat (3) @(negedge clk);

    // Reset during RMW_RD of an SB: abort with no write, core wins afterwards.
    dbg_txn(1'b1, 32'h10, 32'h88776655, 32'h0, "rst_pre");
    core_req_i = 1'b1; core_we_i = 1'b1; core_funct3_i = 3'd0;
    core_addr_i = 32'h11; core_wdata_i = 32'hAB;
    #1;
    t = 0;
    while (!core_ready_o && t < 20) begin @(negedge clk); t++; end
    chk("rst_sb_ready", 32'(core_ready_o), 1);
    @(negedge clk);
    chk("rst_rmw_rd_en", 32'(ram_en_o & ~ram_we_o), 1);
    arst_n = 1'b0;
    core_we_i = 1'b0; core_funct3_i = 3'd2; core_addr_i = 32'h10;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h10;
    @(negedge clk);
    chk("rst_abort_busy", 32'(busy_o), 0);
    chk("rst_abort_ram", 32'({ram_en_o, ram_we_o}), 0);
    chk("rst_abort_ready", 32'({core_ready_o, dbg_ready_o}), 0);
    chk("rst_abort_pulses", 32'({core_rvalid_o, dbg_rvalid_o, core_err_o}), 0);
    chk("rst_abort_core_rdata", core_rdata_o, 0);
    chk("rst_abort_dbg_rdata", dbg_rdata_o, 0);
    @(negedge clk);
    chk("rst_hold_we", 32'(ram_we_o), 0);
    arst_n = 1'b1;
    #1;
    chk("rst_core_first", 32'(core_ready_o), 1);
    chk("rst_dbg_waits", 32'(dbg_ready_o), 0);
    crd_q.push_back(32'h88776655);
    @(negedge clk);
    core_req_i = 1'b0;
    t = 0;
    while (!dbg_ready_o && t < 20) begin @(negedge clk); t++; end
    chk("rst_dbg_after", 32'(dbg_ready_o), 1);
    drd_q.push_back(32'h88776655);
    @(negedge clk);
    dbg_req_i = 1'b0;
    repeat (4) @(negedge clk);

    chk("sb_drained", 32'(crd_q.size() + drd_q.size() + wr_q.size() + err_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
